// File: rtl/download_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : download_buffer_if
// Purpose  : Pixel write/read ports and the writer/reader command handshake
//            that connect the ping-pong row buffer to its writer and LCD reader.
// Revision : 1.0  initial release
// ============================================================================
interface download_buffer_if #(
    parameter int ADDR_WIDTH = 11
);
    // Writer pixel port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data;
    logic                  mem_data_en;
    // Reader pixel port
    logic [ADDR_WIDTH-1:0] lcd_addr;
    logic [15:0]           lcd_data;
    // Writer command channel
    logic [1:0]            command_data_in;
    logic                  command_available_in;
    logic                  buffer_rdy;
    // Forwarded command channel to the reader
    logic [1:0]            command_data_out;
    logic                  command_available_out;
    logic                  command_ack;

    // Environment side: drives pixels, commands and acks
    modport master (
        output mem_addr, mem_data, mem_data_en, lcd_addr,
        output command_data_in, command_available_in, command_ack,
        input  lcd_data, buffer_rdy, command_data_out, command_available_out
    );

    // Buffer side
    modport slave (
        input  mem_addr, mem_data, mem_data_en, lcd_addr,
        input  command_data_in, command_available_in, command_ack,
        output lcd_data, buffer_rdy, command_data_out, command_available_out
    );
endinterface
`default_nettype wire

// File: rtl/download_buffer.sv
`default_nettype none
// ============================================================================
// Module   : download_buffer
// Purpose  : Two-bank ping-pong row buffer. The writer fills one bank while the
//            LCD reader reads the other asynchronously; a "row ready" command
//            swaps the banks and is forwarded to the reader with an ack
//            handshake. Holds one forwarded command at a time.
// Revision : 1.0  initial release
// ============================================================================
module download_buffer #(
    parameter int LOG_LEVEL  = 0,
    parameter int ADDR_WIDTH = 11
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          init,
    download_buffer_if.slave   bus
);

    localparam int         c_MEM_WORDS = 2 ** (ADDR_WIDTH + 1);
    localparam logic [1:0] c_CMD_FRAME = 2'd1;
    localparam logic [1:0] c_CMD_ROW   = 2'd2;

    // LOG_LEVEL controls simulation logging only; it creates no logic.
    if (LOG_LEVEL > 0) begin : g_log_hook
    end

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } slot_state_t;

    // Both banks live in one array; the MSB of the index is the bank number.
    logic [15:0]  r_mem [0:c_MEM_WORDS-1];

    slot_state_t  r_state;
    slot_state_t  w_state_next;
    logic         r_wbank;
    logic         w_wbank_next;
    logic         r_armed;
    logic         w_armed_next;
    logic         r_buffer_rdy;
    logic [1:0]   r_cmd_out;
    logic [1:0]   w_cmd_out_next;
    logic         w_soft_clear;
    logic         w_accept;

    assign w_soft_clear = reset | init;

    // A command is taken only once per rising valid and only when the
    // forwarded slot is empty; an ack in the same cycle frees the slot for
    // the following cycle, so the new command waits one extra cycle.
    assign w_accept = bus.command_available_in & r_armed & (r_state == S_IDLE);

    // Pixel write into the current write bank; a simultaneous swap takes
    // effect after this edge, so the write lands in the pre-swap bank.
    always_ff @(posedge clk) begin
        if (!w_soft_clear && bus.mem_data_en) begin
            r_mem[{r_wbank, bus.mem_addr}] <= bus.mem_data;
        end
    end

    // Asynchronous read from the bank opposite the write bank.
    assign bus.lcd_data = r_mem[{~r_wbank, bus.lcd_addr}];

    // Control state register; reset and init both clear it (memory untouched).
    always_ff @(posedge clk) begin
        if (w_soft_clear) begin
            r_state      <= S_IDLE;
            r_wbank      <= 1'b0;
            r_armed      <= 1'b0;
            r_buffer_rdy <= 1'b0;
            r_cmd_out    <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_wbank      <= w_wbank_next;
            r_armed      <= w_armed_next;
            r_buffer_rdy <= w_accept;
            r_cmd_out    <= w_cmd_out_next;
        end
    end

    // Next-state logic for the forwarded-command slot, bank select and arming.
    always_comb begin
        w_state_next   = r_state;
        w_wbank_next   = r_wbank;
        w_armed_next   = r_armed;
        w_cmd_out_next = r_cmd_out;

        // Re-arm only after valid has been seen low.
        if (!bus.command_available_in) begin
            w_armed_next = 1'b1;
        end
        if (w_accept) begin
            w_armed_next = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.command_data_in)
                        c_CMD_FRAME: begin
                            w_wbank_next   = 1'b0;
                            w_cmd_out_next = c_CMD_FRAME;
                            w_state_next   = S_PENDING;
                        end
                        c_CMD_ROW: begin
                            w_wbank_next   = ~r_wbank;
                            w_cmd_out_next = c_CMD_ROW;
                            w_state_next   = S_PENDING;
                        end
                        default: begin
                            // No-op commands only earn the acknowledge pulse.
                        end
                    endcase
                end
            end
            S_PENDING: begin
                if (bus.command_ack) begin
                    w_state_next   = S_IDLE;
                    w_cmd_out_next = 2'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.buffer_rdy            = r_buffer_rdy;
    assign bus.command_data_out      = r_cmd_out;
    assign bus.command_available_out = (r_state == S_PENDING);

endmodule
`default_nettype wire

// File: tb/tb_download_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_download_buffer
// Purpose  : Self-checking bench for download_buffer with random pixel data
//            and a two-bank memory / bank-select reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_download_buffer;

    localparam int AW  = 11;
    localparam int ROW = 480;

    logic clk = 1'b0;
    logic reset;
    logic init;
    int   errors = 0;
    int   checks = 0;

    // Reference model: contents of both banks and the current write bank.
    logic [15:0] model_mem [2][2**AW];
    bit          model_wbank;

    always #5 clk = ~clk;

    download_buffer_if #(.ADDR_WIDTH(AW)) bus ();

    download_buffer #(
        .LOG_LEVEL  (0),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .init  (init),
        .bus   (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.mem_addr             = '0;
        bus.mem_data             = '0;
        bus.mem_data_en          = 1'b0;
        bus.lcd_addr             = '0;
        bus.command_data_in      = 2'd0;
        bus.command_available_in = 1'b0;
        bus.command_ack          = 1'b0;
    endtask

    // Raise valid with command c and wait for the acknowledge pulse.
    task automatic issue_cmd(input logic [1:0] c);
        bit seen = 1'b0;
        bus.command_data_in      = c;
        bus.command_available_in = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            cyc();
            if (bus.buffer_rdy === 1'b1) seen = 1'b1;
        end
        bus.command_available_in = 1'b0;
        bus.command_data_in      = 2'd0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cmd_accept: buffer_rdy never seen for cmd %0d, required 1 within 64 cycles", c);
        end
        if (c == 2'd1) model_wbank = 1'b0;
        else if (c == 2'd2) model_wbank = !model_wbank;
    endtask

    // Wait for the forwarded command, check it, ack it, check the slot clears.
    task automatic ack_cmd(input logic [1:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus.command_available_out === 1'b1) seen = 1'b1;
            else cyc();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fwd_valid: command_available_out stayed %b, required 1", bus.command_available_out);
        end
        checks++;
        if (bus.command_data_out !== exp) begin
            errors++;
            $display("FAIL fwd_data: command_data_out=%0d required %0d", bus.command_data_out, exp);
        end
        bus.command_ack = 1'b1;
        cyc();
        bus.command_ack = 1'b0;
        checks++;
        if (bus.command_available_out !== 1'b0 || bus.command_data_out !== 2'd0) begin
            errors++;
            $display("FAIL fwd_clear: avail=%b data=%0d required avail=0 data=0",
                     bus.command_available_out, bus.command_data_out);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        init  = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (bus.buffer_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: buffer_rdy=%b required 0", bus.buffer_rdy);
        end
        checks++;
        if (bus.command_available_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_avail: command_available_out=%b required 0", bus.command_available_out);
        end
        checks++;
        if (bus.command_data_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: command_data_out=%0d required 0", bus.command_data_out);
        end
        reset       = 1'b0;
        model_wbank = 1'b0;
        cyc();
    endtask

    task automatic test_frame_start();
        int hold;
        bus.command_data_in      = 2'd1;
        bus.command_available_in = 1'b1;
        cyc();
        bus.command_available_in = 1'b0;
        bus.command_data_in      = 2'd0;
        model_wbank              = 1'b0;
        checks++;
        if (bus.buffer_rdy !== 1'b1 || bus.command_available_out !== 1'b1 || bus.command_data_out !== 2'd1) begin
            errors++;
            $display("FAIL frame_accept: rdy=%b avail=%b data=%0d required rdy=1 avail=1 data=1",
                     bus.buffer_rdy, bus.command_available_out, bus.command_data_out);
        end
        cyc();
        checks++;
        if (bus.buffer_rdy !== 1'b0) begin
            errors++;
            $display("FAIL frame_rdy_pulse: buffer_rdy=%b required 0 on second cycle", bus.buffer_rdy);
        end
        hold = $urandom_range(6, 2);
        for (int i = 0; i < hold; i++) begin
            cyc();
            checks++;
            if (bus.command_available_out !== 1'b1 || bus.command_data_out !== 2'd1) begin
                errors++;
                $display("FAIL frame_hold: avail=%b data=%0d required avail=1 data=1",
                         bus.command_available_out, bus.command_data_out);
            end
        end
        ack_cmd(2'd1);
    endtask

    task automatic test_row_transfer();
        logic [15:0] d;
        for (int b = 0; b < ROW / 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                if (b * 16 + k != ROW - 1) begin
                    d = 16'($urandom);
                    bus.mem_data_en = 1'b1;
                    bus.mem_addr    = AW'(b * 16 + k);
                    bus.mem_data    = d;
                    model_mem[model_wbank][b * 16 + k] = d;
                    cyc();
                end
            end
            bus.mem_data_en = 1'b0;
            repeat (13) cyc();
        end
        // Last pixel written in the same cycle the row-ready command is taken.
        d = 16'($urandom);
        bus.mem_data_en          = 1'b1;
        bus.mem_addr             = AW'(ROW - 1);
        bus.mem_data             = d;
        model_mem[model_wbank][ROW - 1] = d;
        bus.command_data_in      = 2'd2;
        bus.command_available_in = 1'b1;
        cyc();
        bus.mem_data_en          = 1'b0;
        bus.command_available_in = 1'b0;
        bus.command_data_in      = 2'd0;
        model_wbank              = !model_wbank;
        checks++;
        if (bus.buffer_rdy !== 1'b1 || bus.command_data_out !== 2'd2) begin
            errors++;
            $display("FAIL row_cmd: rdy=%b data=%0d required rdy=1 data=2", bus.buffer_rdy, bus.command_data_out);
        end
        ack_cmd(2'd2);
        for (int a = 0; a < ROW; a++) begin
            bus.lcd_addr = AW'(a);
            #1;
            checks++;
            if (bus.lcd_data !== model_mem[!model_wbank][a]) begin
                errors++;
                $display("FAIL row_read addr %0d: lcd_data=%h required %h", a, bus.lcd_data, model_mem[!model_wbank][a]);
            end
            cyc();
        end
    endtask

    task automatic test_ping_pong();
        logic [15:0] d;
        int w_idx, r_idx, cycles;
        // Prefill row 0 with random gaps.
        w_idx = 0;
        while (w_idx < ROW) begin
            bus.mem_data_en = 1'b0;
            if ($urandom_range(3) != 0) begin
                d = 16'($urandom);
                bus.mem_data_en = 1'b1;
                bus.mem_addr    = AW'(w_idx);
                bus.mem_data    = d;
                model_mem[model_wbank][w_idx] = d;
                w_idx++;
            end
            cyc();
        end
        bus.mem_data_en = 1'b0;
        issue_cmd(2'd2);
        ack_cmd(2'd2);
        for (int n = 0; n < 20; n++) begin
            w_idx  = 0;
            r_idx  = 0;
            cycles = 0;
            while ((r_idx < ROW || (n < 19 && w_idx < ROW)) && cycles < 5000) begin
                bus.mem_data_en = 1'b0;
                if (n < 19 && w_idx < ROW && $urandom_range(3) != 0) begin
                    d = 16'($urandom);
                    bus.mem_data_en = 1'b1;
                    bus.mem_addr    = AW'(w_idx);
                    bus.mem_data    = d;
                    model_mem[model_wbank][w_idx] = d;
                    w_idx++;
                end
                if (r_idx < ROW) begin
                    bus.lcd_addr = AW'(r_idx);
                    #1;
                    checks++;
                    if (bus.lcd_data !== model_mem[!model_wbank][r_idx]) begin
                        errors++;
                        $display("FAIL pingpong row %0d addr %0d: lcd_data=%h required %h",
                                 n, r_idx, bus.lcd_data, model_mem[!model_wbank][r_idx]);
                    end
                    r_idx++;
                end
                cyc();
                cycles++;
            end
            bus.mem_data_en = 1'b0;
            checks++;
            if (cycles >= 5000) begin
                errors++;
                $display("FAIL pingpong_timeout row %0d: read %0d written %0d required %0d", n, r_idx, w_idx, ROW);
            end
            if (n < 19) begin
                issue_cmd(2'd2);
                ack_cmd(2'd2);
            end
        end
    endtask

    task automatic test_backpressure();
        issue_cmd(2'd1);
        cyc();
        bus.command_data_in      = 2'd2;
        bus.command_available_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (bus.buffer_rdy !== 1'b0 || bus.command_available_out !== 1'b1 || bus.command_data_out !== 2'd1) begin
                errors++;
                $display("FAIL bp_wait cycle %0d: rdy=%b avail=%b data=%0d required rdy=0 avail=1 data=1",
                         i, bus.buffer_rdy, bus.command_available_out, bus.command_data_out);
            end
        end
        bus.command_ack = 1'b1;
        cyc();
        bus.command_ack = 1'b0;
        checks++;
        if (bus.buffer_rdy !== 1'b0 || bus.command_available_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack_cycle: rdy=%b avail=%b required rdy=0 avail=0", bus.buffer_rdy, bus.command_available_out);
        end
        cyc();
        bus.command_available_in = 1'b0;
        bus.command_data_in      = 2'd0;
        model_wbank              = !model_wbank;
        checks++;
        if (bus.buffer_rdy !== 1'b1 || bus.command_available_out !== 1'b1 || bus.command_data_out !== 2'd2) begin
            errors++;
            $display("FAIL bp_release: rdy=%b avail=%b data=%0d required rdy=1 avail=1 data=2",
                     bus.buffer_rdy, bus.command_available_out, bus.command_data_out);
        end
        ack_cmd(2'd2);
    endtask

    task automatic test_held_valid_init();
        int          rdy_count = 0;
        logic [15:0] v;
        cyc();
        bus.command_data_in      = 2'd0;
        bus.command_available_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (bus.buffer_rdy === 1'b1) rdy_count++;
            checks++;
            if (bus.command_available_out !== 1'b0) begin
                errors++;
                $display("FAIL held_noop_fwd: command_available_out=%b required 0", bus.command_available_out);
            end
        end
        bus.command_available_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (bus.buffer_rdy === 1'b1) rdy_count++;
        end
        checks++;
        if (rdy_count != 1) begin
            errors++;
            $display("FAIL held_rdy_count: buffer_rdy pulses=%0d required 1", rdy_count);
        end
        // Leave write bank 1 with a forwarded command pending, then init.
        issue_cmd(2'd2);
        ack_cmd(2'd2);
        cyc();
        issue_cmd(2'd2);
        init                     = 1'b1;
        bus.command_ack          = 1'b1;
        bus.command_data_in      = 2'd1;
        bus.command_available_in = 1'b1;
        cyc();
        init                     = 1'b0;
        bus.command_ack          = 1'b0;
        bus.command_available_in = 1'b0;
        bus.command_data_in      = 2'd0;
        model_wbank              = 1'b0;
        checks++;
        if (bus.buffer_rdy !== 1'b0 || bus.command_available_out !== 1'b0 || bus.command_data_out !== 2'd0) begin
            errors++;
            $display("FAIL init_outputs: rdy=%b avail=%b data=%0d required all 0",
                     bus.buffer_rdy, bus.command_available_out, bus.command_data_out);
        end
        // Write bank must now be 0: a write to addr 9 must not show on the read side.
        v = ~model_mem[1][9];
        bus.mem_data_en = 1'b1;
        bus.mem_addr    = AW'(9);
        bus.mem_data    = v;
        model_mem[0][9] = v;
        cyc();
        bus.mem_data_en = 1'b0;
        bus.lcd_addr    = AW'(9);
        #1;
        checks++;
        if (bus.lcd_data !== model_mem[1][9]) begin
            errors++;
            $display("FAIL init_wbank_read: lcd_data=%h required %h", bus.lcd_data, model_mem[1][9]);
        end
        cyc();
        issue_cmd(2'd2);
        bus.lcd_addr = AW'(9);
        #1;
        checks++;
        if (bus.lcd_data !== model_mem[!model_wbank][9]) begin
            errors++;
            $display("FAIL init_wbank_swap: lcd_data=%h required %h", bus.lcd_data, model_mem[!model_wbank][9]);
        end
        ack_cmd(2'd2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_start();
        test_row_transfer();
        test_ping_pong();
        test_backpressure();
        test_held_valid_init();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
